// File: rtl/button_event_detector.sv
// rtl/button_event_detector.sv - synchronised, debounced multi-button press/release/repeat events
// Hold-to-repeat is compiled in only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_detector #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 50_000_000,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             event_valid,
  output logic [IW-1:0]    event_idx
);

  if (N_BTN < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_event_detector: all parameters must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [N_BTN-1:0] sync_meta;
  logic [N_BTN-1:0] sync;
  logic [N_BTN-1:0] db_state;
  logic [CW-1:0]    db_cnt [N_BTN];
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_in;
      sync      <= sync_meta;
    end
  end

  // Level flips on the edge where the mismatch has persisted DEBOUNCE_CYCLES samples.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++) begin
      flip[i] = (sync[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_state      <= '0;
      btn_level     <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        press[i]         <= flip[i] & ~btn_level[i];
        release_pulse[i] <= flip[i] &  btn_level[i];
        if (sync[i] == btn_level[i]) begin
          db_state[i] <= ST_STABLE;
          db_cnt[i]   <= '0;
        end else if (flip[i]) begin
          btn_level[i] <= ~btn_level[i];
          db_state[i]  <= ST_STABLE;
          db_cnt[i]    <= '0;
        end else if (db_state[i] == ST_STABLE) begin
          db_state[i] <= ST_PENDING;
          db_cnt[i]   <= CW'(1);
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0]    hold_cnt [N_BTN];
  logic [N_BTN-1:0] hold_first;

  // A level flip (press or release) restarts the hold timer and wins over a due repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_pulse <= '0;
      hold_first   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (flip[i]) begin
          hold_cnt[i]     <= '0;
          hold_first[i]   <= 1'b1;
          repeat_pulse[i] <= 1'b0;
        end else if (btn_level[i]) begin
          if (hold_cnt[i] == (hold_first[i] ? DELAY_LAST : PERIOD_LAST)) begin
            hold_cnt[i]     <= '0;
            hold_first[i]   <= 1'b0;
            repeat_pulse[i] <= 1'b1;
          end else begin
            hold_cnt[i]     <= hold_cnt[i] + HW'(1);
            repeat_pulse[i] <= 1'b0;
          end
        end else begin
          hold_cnt[i]     <= '0;
          repeat_pulse[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign repeat_pulse = '0;
`endif

  assign ev = press | repeat_pulse;

  // Descending scan so the lowest active index is the one left standing.
  always_comb begin
    event_valid = |ev;
    event_idx   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (ev[i]) event_idx = IW'(i);
    end
  end

endmodule

// File: tb/tb_button_event_detector.sv
// tb/tb_button_event_detector.sv - directed self-checking bench for button_event_detector
module tb_button_event_detector;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_in = 3'b000;
  logic [2:0] btn_level, press, release_pulse, repeat_pulse;
  logic       event_valid;
  logic [1:0] event_idx;

  int tests = 0;
  int fails = 0;
  int press_cnt [3];
  int cnt_before;

  button_event_detector #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .press(press), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .event_valid(event_valid), .event_idx(event_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (press[i] === 1'b1) press_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(btn_level), 0);
    check({tag, "_press"}, 32'(press), 0);
    check({tag, "_release"}, 32'(release_pulse), 0);
    check({tag, "_repeat"}, 32'(repeat_pulse), 0);
    check({tag, "_evvalid"}, 32'(event_valid), 0);
    check({tag, "_evidx"}, 32'(event_idx), 0);
  endtask

  initial begin
    logic exp_rep;
    // reset state
    rst = 1'b1; btn_in = 3'b000;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // clean press on channel 0: press appears at the 6th negedge after the drive
    btn_in = 3'b001;
    tick(5);
    check("p0_early_press", 32'(press), 0);
    check("p0_early_level", 32'(btn_level), 0);
    tick(1);
    check("p0_press", 32'(press), 32'b001);
    check("p0_level", 32'(btn_level), 32'b001);
    check("p0_evvalid", 32'(event_valid), 1);
    check("p0_evidx", 32'(event_idx), 0);
    tick(1);
    check("p0_press_gone", 32'(press), 0);
    check("p0_level_held", 32'(btn_level), 32'b001);

    // release on channel 0
    btn_in = 3'b000;
    tick(5);
    check("r0_early_release", 32'(release_pulse), 0);
    check("r0_early_level", 32'(btn_level), 32'b001);
    tick(1);
    check("r0_release", 32'(release_pulse), 32'b001);
    check("r0_level", 32'(btn_level), 0);
    check("r0_repeat", 32'(repeat_pulse), 0);
    check("r0_evvalid", 32'(event_valid), 0);
    tick(1);
    check("r0_release_gone", 32'(release_pulse), 0);

    // bounce on channel 1: 2-cycle runs are rejected
    for (int k = 0; k < 4; k++) begin
      btn_in = (k % 2 == 0) ? 3'b010 : 3'b000;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        check("b1_bounce_press", 32'(press), 0);
        check("b1_bounce_level", 32'(btn_level), 0);
      end
    end
    btn_in = 3'b010;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      check("b1_settle_press", 32'(press), 0);
    end
    tick(1);
    check("b1_press", 32'(press), 32'b010);
    check("b1_evidx", 32'(event_idx), 1);
    tick(2);
    check("b1_press_count", 32'(press_cnt[1]), 1);
    btn_in = 3'b000;
    tick(8);
    check("b1_released_level", 32'(btn_level), 0);

    // auto-repeat on channel 2, release driven so that it lands on a due repeat
    btn_in = 3'b100;
    tick(6);
    check("a2_press", 32'(press), 32'b100);
    for (int j = 1; j <= 30; j++) begin
      tick(1);
      exp_rep = REP_EN && (j >= 10) && (j < 25) && ((j - 10) % 3 == 0);
      check($sformatf("a2_repeat_%0d", j), 32'(repeat_pulse), 32'({exp_rep, 2'b00}));
      check($sformatf("a2_release_%0d", j), 32'(release_pulse), (j == 25) ? 32'b100 : 0);
      check($sformatf("a2_level_%0d", j), 32'(btn_level), (j < 25) ? 32'b100 : 0);
      check($sformatf("a2_evvalid_%0d", j), 32'(event_valid), 32'(exp_rep));
      check($sformatf("a2_evidx_%0d", j), 32'(event_idx), exp_rep ? 2 : 0);
      if (j == 19) btn_in = 3'b000;
    end
    tick(2);

    // simultaneous press on channels 1 and 2
    btn_in = 3'b110;
    tick(5);
    check("s12_early_press", 32'(press), 0);
    tick(1);
    check("s12_press", 32'(press), 32'b110);
    check("s12_evvalid", 32'(event_valid), 1);
    check("s12_evidx", 32'(event_idx), 1);
    tick(1);
    btn_in = 3'b000;
    tick(6);
    check("s12_release", 32'(release_pulse), 32'b110);
    check("s12_release_evvalid", 32'(event_valid), 0);
    tick(2);

    // reset two cycles before the expected press, button held throughout
    btn_in = 3'b001;
    tick(4);
    rst = 1'b1;
    tick(1);
    check_all_zero("rst_mid_a");
    tick(1);
    check_all_zero("rst_mid_b");
    tick(1);
    check_all_zero("rst_mid_c");
    rst = 1'b0;
    cnt_before = press_cnt[0];
    for (int c = 0; c < 5; c++) begin
      tick(1);
      check("rst_post_early_press", 32'(press), 0);
      check("rst_post_early_level", 32'(btn_level), 0);
    end
    tick(1);
    check("rst_post_press", 32'(press), 32'b001);
    check("rst_post_level", 32'(btn_level), 32'b001);
    tick(3);
    check("rst_post_press_once", 32'(press_cnt[0] - cnt_before), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
